// File: rtl/servo_ramp_if.sv
// Processor register bus plus servo-side write port and status lines of the ramp block.
// Latency: n/a (signal bundle only).
// Backpressure: none; every bus access and every servo write completes in one cycle.
interface servo_ramp_if;
    logic        bus_write_en;
    logic        bus_read_en;
    logic        ramp_en;
    logic [7:0]  bus_addr;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        servo_write_en;
    logic        servo_sel;
    logic [7:0]  servo_addr;
    logic [31:0] servo_wdata;
    logic        busy;
    logic        done_irq;

    // Processor side: issues register accesses, observes servo port and status.
    modport master (
        output bus_write_en, bus_read_en, ramp_en, bus_addr, bus_write_data,
        input  bus_read_data, servo_write_en, servo_sel, servo_addr, servo_wdata,
        input  busy, done_irq
    );

    // Ramp block side.
    modport slave (
        input  bus_write_en, bus_read_en, ramp_en, bus_addr, bus_write_data,
        output bus_read_data, servo_write_en, servo_sel, servo_addr, servo_wdata,
        output busy, done_irq
    );
endinterface

// File: rtl/servo_ramp.sv
// Slew-limited servo mover: walks the servo pulse-compare value toward a programmed target.
// Latency: first servo write INTERVAL cycles after the TARGET write, then every INTERVAL cycles.
// Backpressure: none; register writes always accepted, servo writes are fire-and-forget strobes.
module servo_ramp #(
    parameter logic [31:0] MIN_PULSE    = 32'd50000,
    parameter logic [31:0] MAX_PULSE    = 32'd250000,
    parameter logic [31:0] DEF_STEP     = 32'd1000,
    parameter logic [31:0] DEF_INTERVAL = 32'd2000000
) (
    input  logic        i_pclk,
    input  logic        i_reset,
    servo_ramp_if.slave bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WRITE} state_t;

    state_t      r_state;
    logic [31:0] r_target;
    logic [31:0] r_step;
    logic [31:0] r_interval;
    logic [31:0] r_current;
    logic [31:0] r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_servo_we;
    logic [31:0] r_servo_wdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_wr_target;
    logic        w_idle_match;
    logic        w_done_set;
    logic        w_done_clr;
    logic [31:0] w_tgt_clamp;
    logic [31:0] w_tgt_src;
    logic [31:0] w_step_eff;
    logic [31:0] w_int_eff;
    logic [31:0] w_diff;
    logic [31:0] w_next;
    logic [31:0] w_rdata;

    assign w_wr        = bus.bus_write_en & bus.ramp_en;
    assign w_rd        = bus.bus_read_en & bus.ramp_en;
    assign w_wr_target = w_wr && (bus.bus_addr == 8'h00);
    assign w_step_eff  = (r_step == 32'd0) ? 32'd1 : r_step;
    assign w_int_eff   = (r_interval == 32'd0) ? 32'd1 : r_interval;

    // A fresh TARGET write retargets immediately, so the next value must see it this cycle.
    assign w_tgt_src   = w_wr_target ? w_tgt_clamp : r_target;

    // Already at the clamped target while idle: nothing to move, just report completion.
    assign w_idle_match = w_wr_target && (r_state == ST_IDLE) && (w_tgt_clamp == r_current);
    assign w_done_set   = w_idle_match ||
                          (!w_wr_target && (r_state == ST_WRITE) && (r_current == r_target));
    assign w_done_clr   = w_wr && (bus.bus_addr == 8'h10) && bus.bus_write_data[1];

    // Clamp the incoming target into the servo's legal pulse range.
    always_comb begin
        w_tgt_clamp = bus.bus_write_data;
        if (bus.bus_write_data < MIN_PULSE) begin
            w_tgt_clamp = MIN_PULSE;
        end else if (bus.bus_write_data > MAX_PULSE) begin
            w_tgt_clamp = MAX_PULSE;
        end
    end

    // Next servo value: snap from zero or when within one step, else step toward target.
    // The distance is formed first so neither direction can underflow.
    always_comb begin
        w_next = w_tgt_src;
        w_diff = 32'd0;
        if (r_current != 32'd0) begin
            if (w_tgt_src >= r_current) begin
                w_diff = w_tgt_src - r_current;
                if (w_diff > w_step_eff) begin
                    w_next = r_current + w_step_eff;
                end
            end else begin
                w_diff = r_current - w_tgt_src;
                if (w_diff > w_step_eff) begin
                    w_next = r_current - w_step_eff;
                end
            end
        end
    end

    // Register read mux; idle bus reads as zero.
    always_comb begin
        w_rdata = 32'd0;
        if (w_rd) begin
            case (bus.bus_addr)
                8'h00:   w_rdata = r_target;
                8'h04:   w_rdata = r_step;
                8'h08:   w_rdata = r_interval;
                8'h0C:   w_rdata = r_current;
                8'h10:   w_rdata = {30'd0, r_done, r_busy};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    // Programmable registers and the sticky done flag (a set beats a same-cycle clear).
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_target   <= 32'd0;
            r_step     <= DEF_STEP;
            r_interval <= DEF_INTERVAL;
            r_done     <= 1'b0;
        end else begin
            if (w_wr_target) begin
                r_target <= w_tgt_clamp;
            end
            if (w_wr && (bus.bus_addr == 8'h04)) begin
                r_step <= bus.bus_write_data;
            end
            if (w_wr && (bus.bus_addr == 8'h08)) begin
                r_interval <= bus.bus_write_data;
            end
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end
        end
    end

    // Ramp FSM. The write strobe is registered, so the edge that enters WRITE also
    // launches the servo write and updates CURRENT. A TARGET write overrides whatever
    // the FSM would otherwise do this cycle, including a write that was just due.
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 32'd0;
            r_current     <= 32'd0;
            r_busy        <= 1'b0;
            r_servo_we    <= 1'b0;
            r_servo_wdata <= 32'd0;
        end else begin
            r_servo_we <= 1'b0;
            if (w_wr_target) begin
                if (!w_idle_match) begin
                    r_busy <= 1'b1;
                    if (w_int_eff == 32'd1) begin
                        r_state       <= ST_WRITE;
                        r_servo_we    <= 1'b1;
                        r_servo_wdata <= w_next;
                        r_current     <= w_next;
                    end else begin
                        r_state <= ST_WAIT;
                        r_cnt   <= w_int_eff - 32'd1;
                    end
                end
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        // Counter reaches zero on the edge that enters WRITE.
                        if (r_cnt <= 32'd1) begin
                            r_cnt         <= 32'd0;
                            r_state       <= ST_WRITE;
                            r_servo_we    <= 1'b1;
                            r_servo_wdata <= w_next;
                            r_current     <= w_next;
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
                    ST_WRITE: begin
                        if (r_current == r_target) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if (w_int_eff == 32'd1) begin
                            r_servo_we    <= 1'b1;
                            r_servo_wdata <= w_next;
                            r_current     <= w_next;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= w_int_eff - 32'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.bus_read_data  = w_rdata;
    assign bus.servo_write_en = r_servo_we;
    assign bus.servo_sel      = r_servo_we;
    assign bus.servo_addr     = 8'h00;
    assign bus.servo_wdata    = r_servo_wdata;
    assign bus.busy           = r_busy;
    assign bus.done_irq       = r_done;

endmodule

// File: tb/tb_servo_ramp.sv
// Directed vector bench for servo_ramp: register reads, ramp timing and values, corner cases.
// Latency: checks servo-write spacing in cycles relative to the triggering event.
// Backpressure: none exercised; the block has no flow control.
module tb_servo_ramp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ref_cyc = 0;
    int   last_sw = -1;
    int   checks = 0;
    int   errors = 0;

    servo_ramp_if bus();

    servo_ramp dut (
        .i_pclk  (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {OP_WR, OP_RD, OP_SW, OP_ST, OP_NW} op_e;

    // OP_WR: write data to addr. OP_RD: read addr, expect exp.
    // OP_SW: next servo write has value exp, data cycles after the previous event.
    // OP_ST: advance data cycles then expect {done,busy}==exp.
    // OP_NW: no servo write in the next data cycles.
    typedef struct {
        op_e         op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(op_e op, logic [7:0] a, logic [31:0] d, logic [31:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.bus_write_en   = 1'b1;
        bus.ramp_en        = 1'b1;
        bus.bus_addr       = a;
        bus.bus_write_data = d;
        ref_cyc = cyc;
        @(posedge clk); #1;
        bus.bus_write_en   = 1'b0;
        bus.ramp_en        = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus.bus_read_en = 1'b1;
        bus.ramp_en     = 1'b1;
        bus.bus_addr    = a;
        #1;
        d = bus.bus_read_data;
        bus.bus_read_en = 1'b0;
        bus.ramp_en     = 1'b0;
    endtask

    task automatic wait_sw(input string nm, input int lat, input logic [31:0] val);
        int n;
        n = 0;
        while ((!bus.servo_write_en || cyc == last_sw) && n < lat + 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.servo_write_en || cyc == last_sw) begin
            checks++;
            errors++;
            $display("FAIL %s: no servo write within %0d cycles, expected value %0d", nm, lat + 10, val);
        end else begin
            chk({nm, " latency"}, cyc - ref_cyc, lat);
            chk({nm, " value"}, bus.servo_wdata, val);
            chk({nm, " sel/addr"}, {23'd0, bus.servo_sel, bus.servo_addr}, 32'h100);
            last_sw = cyc;
            ref_cyc = cyc;
        end
    endtask

    task automatic no_write(input string nm, input int n);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.servo_write_en) seen = 1'b1;
        end
        chk({nm, " no servo write"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        string nm;

        bus.bus_write_en   = 1'b0;
        bus.bus_read_en    = 1'b0;
        bus.ramp_en        = 1'b0;
        bus.bus_addr       = 8'h00;
        bus.bus_write_data = 32'd0;

        vecs.push_back(mk(OP_RD, 8'h04, 0, 1000));
        vecs.push_back(mk(OP_RD, 8'h08, 0, 2000000));
        vecs.push_back(mk(OP_RD, 8'h0C, 0, 0));
        vecs.push_back(mk(OP_RD, 8'h10, 0, 0));
        vecs.push_back(mk(OP_NW, 8'h00, 3, 0));
        vecs.push_back(mk(OP_WR, 8'h08, 4, 0));
        vecs.push_back(mk(OP_RD, 8'h08, 0, 4));
        vecs.push_back(mk(OP_WR, 8'h00, 100000, 0));
        vecs.push_back(mk(OP_ST, 8'h00, 0, 2'b01));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 100000));       // snap from zero
        vecs.push_back(mk(OP_ST, 8'h00, 1, 2'b10));
        vecs.push_back(mk(OP_RD, 8'h0C, 0, 100000));
        vecs.push_back(mk(OP_RD, 8'h10, 0, 2));
        vecs.push_back(mk(OP_WR, 8'h10, 2, 0));            // clear done
        vecs.push_back(mk(OP_ST, 8'h00, 0, 2'b00));
        vecs.push_back(mk(OP_RD, 8'h14, 0, 0));
        vecs.push_back(mk(OP_WR, 8'h00, 103500, 0));       // up-ramp with final partial step
        vecs.push_back(mk(OP_SW, 8'h00, 4, 101000));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102000));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 103000));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 103500));
        vecs.push_back(mk(OP_ST, 8'h00, 1, 2'b10));
        vecs.push_back(mk(OP_WR, 8'h00, 10, 0));           // clamps to 50000, ramps down
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102500));
        vecs.push_back(mk(OP_RD, 8'h00, 0, 50000));
        vecs.push_back(mk(OP_WR, 8'h00, 999999, 0));       // clamps to 250000, retarget up
        vecs.push_back(mk(OP_SW, 8'h00, 4, 103500));
        vecs.push_back(mk(OP_RD, 8'h00, 0, 250000));
        vecs.push_back(mk(OP_RD, 8'h0C, 0, 103500));
        vecs.push_back(mk(OP_WR, 8'h00, 100000, 0));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102500));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 101500));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 100500));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 100000));
        vecs.push_back(mk(OP_ST, 8'h00, 1, 2'b10));
        vecs.push_back(mk(OP_WR, 8'h10, 2, 0));
        vecs.push_back(mk(OP_ST, 8'h00, 0, 2'b00));
        vecs.push_back(mk(OP_WR, 8'h00, 100000, 0));       // already there: done, no write
        vecs.push_back(mk(OP_ST, 8'h00, 0, 2'b10));
        vecs.push_back(mk(OP_NW, 8'h00, 6, 0));
        vecs.push_back(mk(OP_ST, 8'h00, 0, 2'b10));
        vecs.push_back(mk(OP_WR, 8'h00, 103500, 0));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 101000));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102000));
        vecs.push_back(mk(OP_WR, 8'h00, 101500, 0));       // mid-ramp retarget, counter restarts
        vecs.push_back(mk(OP_SW, 8'h00, 4, 101500));
        vecs.push_back(mk(OP_ST, 8'h00, 1, 2'b10));
        vecs.push_back(mk(OP_WR, 8'h00, 103500, 0));
        vecs.push_back(mk(OP_NW, 8'h00, 2, 0));
        vecs.push_back(mk(OP_WR, 8'h00, 102000, 0));       // lands on the due-write cycle
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102000));
        vecs.push_back(mk(OP_ST, 8'h00, 1, 2'b10));
        vecs.push_back(mk(OP_WR, 8'h04, 0, 0));            // STEP=0 acts as 1
        vecs.push_back(mk(OP_WR, 8'h00, 102003, 0));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102001));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102002));
        vecs.push_back(mk(OP_SW, 8'h00, 4, 102003));
        vecs.push_back(mk(OP_WR, 8'h04, 1000, 0));
        vecs.push_back(mk(OP_WR, 8'h08, 0, 0));            // INTERVAL=0 acts as 1
        vecs.push_back(mk(OP_ST, 8'h00, 1, 2'b10));
        vecs.push_back(mk(OP_WR, 8'h00, 105000, 0));
        vecs.push_back(mk(OP_SW, 8'h00, 1, 103003));
        vecs.push_back(mk(OP_SW, 8'h00, 1, 104003));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset servo_write_en", {31'd0, bus.servo_write_en}, 32'd0);
        chk("reset servo_wdata", bus.servo_wdata, 32'd0);
        chk("reset busy/done", {30'd0, bus.done_irq, bus.busy}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            nm = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OP_WR: bus_write(vecs[i].addr, vecs[i].data);
                OP_RD: begin
                    bus_read(vecs[i].addr, rd);
                    chk({nm, " read"}, rd, vecs[i].exp);
                end
                OP_SW: wait_sw(nm, int'(vecs[i].data), vecs[i].exp);
                OP_ST: begin
                    for (int k = 0; k < int'(vecs[i].data); k++) begin
                        @(posedge clk); #1;
                    end
                    chk({nm, " done/busy"}, {30'd0, bus.done_irq, bus.busy}, vecs[i].exp);
                end
                OP_NW: no_write(nm, int'(vecs[i].data));
                default: ;
            endcase
        end

        // Reset in the middle of a one-cycle-interval ramp (104003 -> 105000 pending).
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midramp reset servo_write_en", {31'd0, bus.servo_write_en}, 32'd0);
        chk("midramp reset busy/done", {30'd0, bus.done_irq, bus.busy}, 32'd0);
        chk("midramp reset servo_wdata", bus.servo_wdata, 32'd0);
        rst = 1'b0;
        bus_read(8'h0C, rd);
        chk("post-reset CURRENT", rd, 32'd0);
        bus_read(8'h04, rd);
        chk("post-reset STEP", rd, 32'd1000);
        bus_read(8'h08, rd);
        chk("post-reset INTERVAL", rd, 32'd2000000);
        no_write("post-reset", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
